pass_checker: RTL and testbench

- Read side of the lock's password register: compares the entered 4-bit code against the stored password on each Enter press.
- Drives the unlock output and counts wrong attempts.
- Forces a timed lockout after too many consecutive failures.
- Sits beside the password-update logic, consuming its stored-password output, and feeds the top-level lock FSM and LEDs.

---
 rtl/pass_checker.sv | 138 +++++++++++++
 tb/tb_pass_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pass_checker.sv
// pass_checker
// Password comparison stage of the lock. Compares the entered code against the
// stored password on each Enter press. A correct press opens the lock for a
// fixed time. Each wrong press pulses an error flag and increments a
// consecutive-failure count. When that count reaches MAX_TRIES, the block
// forces a timed lockout.
//
// Ports:
//   Clk        - system clock, rising edge
//   Reset      - asynchronous active-high reset
//   inps       - entered 4-bit code
//   storedPass - current stored password (sampled only on a press edge)
//   enter      - Enter button level, synchronous to Clk
//   unlocked   - high while the lock is open (OPEN_CYCLES cycles)
//   attemptErr - one-cycle pulse per wrong entry
//   lockedOut  - high during the lockout period (LOCK_CYCLES cycles)
//   tries      - current consecutive wrong-entry count
module pass_checker #(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned TRIES_W    = $clog2(MAX_TRIES + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         inps,
    input  logic [3:0]         storedPass,
    input  logic               enter,
    output logic               unlocked,
    output logic               attemptErr,
    output logic               lockedOut,
    output logic [TRIES_W-1:0] tries
);

    localparam int unsigned MAX_CYCLES = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    // Keep at least one timer bit when both durations are a single cycle.
    localparam int unsigned TIMER_W    = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StErr,
        StLock
    } state_e;

    state_e             r_state;
    logic               r_enter_q;
    logic [TIMER_W-1:0] r_timer;
    logic [TRIES_W-1:0] r_tries;
    logic               r_unlocked;
    logic               r_attempt_err;
    logic               r_locked_out;

    logic               w_press;
    logic               w_match;
    logic [TRIES_W-1:0] w_tries_inc;

    // Rising edge of the Enter level; holding the button gives a single press.
    assign w_press     = enter & ~r_enter_q;
    assign w_match     = (inps == storedPass);
    assign w_tries_inc = r_tries + TRIES_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= StIdle;
            r_enter_q     <= 1'b0;
            r_timer       <= '0;
            r_tries       <= '0;
            r_unlocked    <= 1'b0;
            r_attempt_err <= 1'b0;
            r_locked_out  <= 1'b0;
        end else begin
            r_enter_q     <= enter;
            // The error flag is a single-cycle pulse from whichever edge set it.
            r_attempt_err <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_press) begin
                        if (w_match) begin
                            r_state    <= StOpen;
                            r_tries    <= '0;
                            r_timer    <= OPEN_LOAD;
                            r_unlocked <= 1'b1;
                        end else if (w_tries_inc == TRIES_MAX) begin
                            r_state       <= StLock;
                            r_tries       <= TRIES_MAX;
                            r_timer       <= LOCK_LOAD;
                            r_locked_out  <= 1'b1;
                            r_attempt_err <= 1'b1;
                        end else begin
                            r_state       <= StErr;
                            r_tries       <= w_tries_inc;
                            r_attempt_err <= 1'b1;
                        end
                    end
                end

                StErr: begin
                    r_state <= StIdle;
                end

                StOpen: begin
                    if (r_timer == '0) begin
                        r_state    <= StIdle;
                        r_unlocked <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                StLock: begin
                    if (r_timer == '0) begin
                        r_state      <= StIdle;
                        r_tries      <= '0;
                        r_locked_out <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign unlocked   = r_unlocked;
    assign attemptErr = r_attempt_err;
    assign lockedOut  = r_locked_out;
    assign tries      = r_tries;

endmodule

// File: tb/tb_pass_checker.sv
// Scoreboard bench for pass_checker. The driver computes the expected outputs
// for every clock edge from a behavioural model and queues them. The monitor
// pops one entry after every edge and compares it with the DUT outputs.
module tb_pass_checker;

    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned OPEN_CYCLES = 8;
    localparam int unsigned LOCK_CYCLES = 16;
    localparam int unsigned TRIES_W     = $clog2(MAX_TRIES + 1);

    logic               Clk;
    logic               Reset;
    logic [3:0]         inps;
    logic [3:0]         storedPass;
    logic               enter;
    logic               unlocked;
    logic               attemptErr;
    logic               lockedOut;
    logic [TRIES_W-1:0] tries;

    pass_checker #(
        .MAX_TRIES  (MAX_TRIES),
        .OPEN_CYCLES(OPEN_CYCLES),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .inps      (inps),
        .storedPass(storedPass),
        .enter     (enter),
        .unlocked  (unlocked),
        .attemptErr(attemptErr),
        .lockedOut (lockedOut),
        .tries     (tries)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic               unl;
        logic               err;
        logic               lck;
        logic [TRIES_W-1:0] tr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: remaining open/lock cycles, failure count, and a flag
    // for the single cooling-off cycle after a non-locking wrong entry.
    int   m_open_left;
    int   m_lock_left;
    int   m_fails;
    bit   m_cooling;
    bit   m_pulse;
    bit   m_prev_enter;

    function automatic void model_reset();
        m_open_left  = 0;
        m_lock_left  = 0;
        m_fails      = 0;
        m_cooling    = 0;
        m_pulse      = 0;
        m_prev_enter = 0;
    endfunction

    function automatic void model_step(input logic en, input logic [3:0] code,
                                       input logic [3:0] pass);
        bit press;
        bit busy;
        press        = en && !m_prev_enter;
        m_prev_enter = en;
        m_pulse      = 0;
        busy         = (m_open_left > 0) || (m_lock_left > 0) || m_cooling;
        if (busy) begin
            m_cooling = 0;
            if (m_open_left > 0) m_open_left--;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end
        end else if (press) begin
            if (code == pass) begin
                m_fails     = 0;
                m_open_left = OPEN_CYCLES;
            end else begin
                m_fails++;
                m_pulse = 1;
                if (m_fails >= MAX_TRIES) m_lock_left = LOCK_CYCLES;
                else m_cooling = 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.unl = (m_open_left > 0);
        e.err = m_pulse;
        e.lck = (m_lock_left > 0);
        e.tr  = TRIES_W'(m_fails);
        return e;
    endfunction

    // One clock of stimulus: drive on the falling edge, queue what the next
    // rising edge must produce.
    task automatic cyc(input logic en, input logic [3:0] code, input logic [3:0] pass);
        @(negedge Clk);
        enter      = en;
        inps       = code;
        storedPass = pass;
        model_step(en, code, pass);
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n, input logic [3:0] pass);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, pass);
    endtask

    task automatic press(input logic [3:0] code, input logic [3:0] pass);
        cyc(1'b1, code, pass);
        cyc(1'b0, code, pass);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check_val({tag, " unlocked"}, int'(unlocked), 0);
        check_val({tag, " attemptErr"}, int'(attemptErr), 0);
        check_val({tag, " lockedOut"}, int'(lockedOut), 0);
        check_val({tag, " tries"}, int'(tries), 0);
        enter = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    exp_t mon_e;
    always @(posedge Clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({unlocked, attemptErr, lockedOut, tries} != mon_e) begin
                errors++;
                $display("FAIL outputs t=%0t: got unl=%b err=%b lck=%b tries=%0d, expected unl=%b err=%b lck=%b tries=%0d",
                         $time, unlocked, attemptErr, lockedOut, tries,
                         mon_e.unl, mon_e.err, mon_e.lck, mon_e.tr);
            end
        end
    end

    initial begin
        logic [3:0] pass;
        logic [3:0] code;
        logic       en;

        Reset      = 1'b1;
        enter      = 1'b0;
        inps       = 4'h0;
        storedPass = 4'h0;
        model_reset();
        #12;
        check_val("reset unlocked", int'(unlocked), 0);
        check_val("reset tries", int'(tries), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Correct entry opens for OPEN_CYCLES cycles.
        pass = 4'b0110;
        press(4'b0110, pass);
        idle(10, pass);

        // Enter held high gives a single wrong-entry pulse.
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'b0101, pass);
        idle(3, pass);

        // Reset mid-cycle clears the failure count.
        async_reset("async");

        // Three wrong entries lock out; a correct press during lockout is ignored.
        press(4'b0000, pass);
        idle(1, pass);
        press(4'b1111, pass);
        idle(1, pass);
        press(4'b0001, pass);
        idle(3, pass);
        press(4'b0110, pass);
        idle(14, pass);

        // Two wrong, then correct: count clears, a later wrong entry does not lock.
        press(4'b0000, pass);
        idle(1, pass);
        press(4'b0011, pass);
        idle(1, pass);
        press(4'b0110, pass);
        idle(9, pass);
        press(4'b1000, pass);
        idle(3, pass);

        // Password change honoured at the next press; reset aborts the open period.
        idle(2, 4'b1010);
        pass = 4'b1010;
        press(4'b1010, pass);
        idle(2, pass);
        async_reset("open abort");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) pass = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 2) == 0);
            code = ($urandom_range(0, 2) == 0) ? pass : 4'($urandom_range(0, 15));
            cyc(en, code, pass);
        end
        idle(3, pass);

        @(negedge Clk);
        check_val("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
